// File: rtl/round_controller_pkg.sv
// Shared constants for the round controller: state encoding, symbol codes and string width.
package round_controller_pkg;

  localparam int unsigned STR_W  = 64;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CHECK   = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  // Unary symbol codes, right-aligned in CODE_W bits
  localparam logic [CODE_W-1:0] TOGGLE_CODE = 5'b00010;
  localparam logic [CODE_W-1:0] PUSH_CODE   = 5'b00110;
  localparam logic [CODE_W-1:0] MIC_CODE    = 5'b01110;
  localparam logic [CODE_W-1:0] MOUSE_CODE  = 5'b11110;

  localparam logic [LEN_W-1:0] TOGGLE_LEN = 3'd2;
  localparam logic [LEN_W-1:0] PUSH_LEN   = 3'd3;
  localparam logic [LEN_W-1:0] MIC_LEN    = 3'd4;
  localparam logic [LEN_W-1:0] MOUSE_LEN  = 3'd5;

endpackage

// File: rtl/round_controller_input_edge_arbiter.sv
// Rising-edge detection on the four player inputs with fixed-priority selection of one symbol.
module input_edge_arbiter
  import round_controller_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              toggle,
  input  logic              push,
  input  logic              mic,
  input  logic              mouse,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [LEN_W-1:0]  len
);

  logic [3:0] x;
  logic [3:0] x_d;
  logic [3:0] edges;

  assign x     = {toggle, push, mic, mouse};
  assign edges = x & ~x_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) x_d <= '0;
    else       x_d <= x;
  end

  // Lower-priority edges in the same cycle are dropped
  always_comb begin
    valid = 1'b0;
    code  = '0;
    len   = '0;
    if (edges[3]) begin
      valid = 1'b1; code = TOGGLE_CODE; len = TOGGLE_LEN;
    end else if (edges[2]) begin
      valid = 1'b1; code = PUSH_CODE;   len = PUSH_LEN;
    end else if (edges[1]) begin
      valid = 1'b1; code = MIC_CODE;    len = MIC_LEN;
    end else if (edges[0]) begin
      valid = 1'b1; code = MOUSE_CODE;  len = MOUSE_LEN;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game-round sequencer: captures arbitrated symbols into a string, compares to target, tracks score and lives.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned MAX_SYMBOLS    = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             toggle,
  input  logic             push,
  input  logic             mic,
  input  logic             mouse,
  input  logic [STR_W-1:0] target,
  input  logic [3:0]       target_len,
  output logic [STR_W-1:0] string_out,
  output logic [3:0]       sym_count,
  output logic [7:0]       score,
  output logic [3:0]       lives,
  output logic [2:0]       state,
  output logic             win,
  output logic             lose,
  output logic             game_over
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t             st;
  logic [TW-1:0]      timer;
  logic               valid;
  logic [CODE_W-1:0]  code;
  logic [LEN_W-1:0]   len;
  logic               len_ok;
  logic [3:0]         next_count;

  input_edge_arbiter u_arb (
    .clock  (clock),
    .reset  (reset),
    .toggle (toggle),
    .push   (push),
    .mic    (mic),
    .mouse  (mouse),
    .valid  (valid),
    .code   (code),
    .len    (len)
  );

  assign state      = st;
  assign len_ok     = (target_len != 4'd0) && (target_len <= 4'(MAX_SYMBOLS));
  assign next_count = sym_count + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= S_IDLE;
      string_out <= '0;
      sym_count  <= '0;
      timer      <= '0;
      score      <= '0;
      lives      <= 4'(LIVES);
      win        <= 1'b0;
      lose       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      win  <= 1'b0;
      lose <= 1'b0;
      case (st)
        S_IDLE: begin
          string_out <= '0;
          sym_count  <= '0;
          timer      <= '0;
          if (start && len_ok) st <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // An accept takes precedence over a coincident timeout
          if (valid) begin
            string_out <= (string_out << len) | STR_W'(code);
            sym_count  <= next_count;
            timer      <= '0;
            if (next_count == target_len) st <= S_CHECK;
          end else if (timer == TIMER_LAST) begin
            st    <= S_LOSE;
            lose  <= 1'b1;
            lives <= (lives != 4'd0) ? lives - 4'd1 : lives;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_CHECK: begin
          if (string_out == target) begin
            st    <= S_WIN;
            win   <= 1'b1;
            score <= (score != 8'hFF) ? score + 8'd1 : score;
          end else begin
            st    <= S_LOSE;
            lose  <= 1'b1;
            lives <= (lives != 4'd0) ? lives - 4'd1 : lives;
          end
        end
        S_WIN: begin
          st         <= S_IDLE;
          string_out <= '0;
          sym_count  <= '0;
        end
        S_LOSE: begin
          if (lives == 4'd0) begin
            st        <= S_OVER;
            game_over <= 1'b1;
          end else begin
            st         <= S_IDLE;
            string_out <= '0;
            sym_count  <= '0;
          end
        end
        S_OVER: game_over <= 1'b1;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller (TIMEOUT_CYCLES=8, LIVES=3).
module tb_round_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, toggle, push, mic, mouse;
  logic [63:0] target;
  logic [3:0]  target_len;
  logic [63:0] string_out;
  logic [3:0]  sym_count;
  logic [7:0]  score;
  logic [3:0]  lives;
  logic [2:0]  state;
  logic        win, lose, game_over;

  int tests = 0;
  int fails = 0;

  round_controller #(.TIMEOUT_CYCLES(8), .LIVES(3), .MAX_SYMBOLS(12)) dut (
    .clock(clock), .reset(reset), .start(start),
    .toggle(toggle), .push(push), .mic(mic), .mouse(mouse),
    .target(target), .target_len(target_len),
    .string_out(string_out), .sym_count(sym_count), .score(score),
    .lives(lives), .state(state), .win(win), .lose(lose), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; toggle = 0; push = 0; mic = 0; mouse = 0;
    target = '0; target_len = '0;
    step(); step();
    reset = 1'b0;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if (lives !== 4'd3) begin fails++; $display("FAIL reset_lives: got %0d want 3", lives); end
    tests++; if (score !== 8'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", score); end
    tests++; if (string_out !== 64'd0 || sym_count !== 4'd0) begin
      fails++; $display("FAIL reset_string: got %h/%0d want 0/0", string_out, sym_count); end
    tests++; if ({win, lose, game_over} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {win, lose, game_over}); end
  endtask

  task automatic test_capture_win(input logic [7:0] exp_score);
    target = 64'h16; target_len = 4'd2; start = 1;
    step(); start = 0;
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL cw_enter: got %0d want 1", state); end
    toggle = 1; step(); toggle = 0;
    tests++; if (string_out !== 64'h2 || sym_count !== 4'd1) begin
      fails++; $display("FAIL cw_first: got %h/%0d want 2/1", string_out, sym_count); end
    push = 1; step(); push = 0;
    tests++; if (string_out !== 64'h16 || sym_count !== 4'd2 || state !== 3'd2) begin
      fails++; $display("FAIL cw_second: got %h/%0d/st%0d want 16/2/st2", string_out, sym_count, state); end
    step();
    tests++; if (state !== 3'd3 || win !== 1'b1 || score !== exp_score) begin
      fails++; $display("FAIL cw_win: got st%0d win%b score%0d want st3 win1 score%0d", state, win, score, exp_score); end
    step();
    tests++; if (state !== 3'd0 || win !== 1'b0 || string_out !== 64'd0) begin
      fails++; $display("FAIL cw_idle: got st%0d win%b str%h want st0 win0 str0", state, win, string_out); end
  endtask

  task automatic test_mismatch();
    target = 64'h1E; target_len = 4'd1; start = 1;
    step(); start = 0;
    mic = 1; step(); mic = 0;
    tests++; if (string_out !== 64'hE || state !== 3'd2) begin
      fails++; $display("FAIL mm_string: got %h/st%0d want e/st2", string_out, state); end
    step();
    tests++; if (state !== 3'd4 || lose !== 1'b1 || lives !== 4'd2) begin
      fails++; $display("FAIL mm_lose: got st%0d lose%b lives%0d want st4 lose1 lives2", state, lose, lives); end
    step();
    tests++; if (state !== 3'd0 || lose !== 1'b0) begin
      fails++; $display("FAIL mm_idle: got st%0d lose%b want st0 lose0", state, lose); end
  endtask

  task automatic test_simultaneous();
    target = 64'h16; target_len = 4'd2; start = 1;
    step(); start = 0;
    toggle = 1; mic = 1; step(); toggle = 0;
    tests++; if (string_out !== 64'h2 || sym_count !== 4'd1) begin
      fails++; $display("FAIL sim_priority: got %h/%0d want 2/1", string_out, sym_count); end
    step(); step();
    tests++; if (string_out !== 64'h2 || sym_count !== 4'd1) begin
      fails++; $display("FAIL sim_held: got %h/%0d want 2/1", string_out, sym_count); end
    mic = 0; push = 1; step(); push = 0;
    tests++; if (string_out !== 64'h16 || state !== 3'd2) begin
      fails++; $display("FAIL sim_push: got %h/st%0d want 16/st2", string_out, state); end
    step();
    tests++; if (state !== 3'd3 || score !== 8'd2) begin
      fails++; $display("FAIL sim_win: got st%0d score%0d want st3 score2", state, score); end
    step();
  endtask

  task automatic test_timeout();
    target = 64'h0; target_len = 4'd2; start = 1;
    step(); start = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      tests++; if (state !== 3'd1) begin fails++; $display("FAIL to_wait%0d: got st%0d want st1", i, state); end
    end
    step();
    tests++; if (state !== 3'd4 || lose !== 1'b1 || lives !== 4'd1) begin
      fails++; $display("FAIL to_lose: got st%0d lose%b lives%0d want st4 lose1 lives1", state, lose, lives); end
    step();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL to_idle: got st%0d want st0", state); end
  endtask

  task automatic test_timeout_accept_game_over();
    target = 64'h0; target_len = 4'd2; start = 1;
    step(); start = 0;
    for (int i = 1; i <= 7; i++) step();
    toggle = 1; step(); toggle = 0;
    tests++; if (state !== 3'd1 || sym_count !== 4'd1) begin
      fails++; $display("FAIL ta_accept: got st%0d cnt%0d want st1 cnt1", state, sym_count); end
    for (int i = 1; i <= 7; i++) step();
    tests++; if (state !== 3'd1) begin fails++; $display("FAIL ta_rearm: got st%0d want st1", state); end
    step();
    tests++; if (state !== 3'd4 || lives !== 4'd0) begin
      fails++; $display("FAIL ta_lose: got st%0d lives%0d want st4 lives0", state, lives); end
    step();
    tests++; if (state !== 3'd5 || game_over !== 1'b1) begin
      fails++; $display("FAIL go_enter: got st%0d go%b want st5 go1", state, game_over); end
    target_len = 4'd2; start = 1; toggle = 1;
    step(); step(); step();
    start = 0; toggle = 0;
    tests++; if (state !== 3'd5 || game_over !== 1'b1 || sym_count !== 4'd1) begin
      fails++; $display("FAIL go_sticky: got st%0d go%b cnt%0d want st5 go1 cnt1", state, game_over, sym_count); end
    reset = 1; step(); reset = 0;
    tests++; if (state !== 3'd0 || lives !== 4'd3 || game_over !== 1'b0) begin
      fails++; $display("FAIL go_reset: got st%0d lives%0d go%b want st0 lives3 go0", state, lives, game_over); end
  endtask

  task automatic test_guards_reset();
    target_len = 4'd0; start = 1; step();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL guard_len0: got st%0d want st0", state); end
    target_len = 4'd13; step(); start = 0;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL guard_len13: got st%0d want st0", state); end
    target_len = 4'd2; start = 1; toggle = 1; step(); start = 0;
    tests++; if (state !== 3'd1 || sym_count !== 4'd0) begin
      fails++; $display("FAIL guard_start_edge: got st%0d cnt%0d want st1 cnt0", state, sym_count); end
    step();
    tests++; if (sym_count !== 4'd0) begin fails++; $display("FAIL guard_held: got %0d want 0", sym_count); end
    toggle = 0; step();
    toggle = 1; step(); toggle = 0;
    tests++; if (string_out !== 64'h2 || sym_count !== 4'd1) begin
      fails++; $display("FAIL mid_capture: got %h/%0d want 2/1", string_out, sym_count); end
    #2 reset = 1;
    #1;
    tests++; if (state !== 3'd0 || string_out !== 64'd0 || sym_count !== 4'd0) begin
      fails++; $display("FAIL mid_reset: got st%0d str%h cnt%0d want st0 str0 cnt0", state, string_out, sym_count); end
    tests++; if (score !== 8'd0 || lives !== 4'd3) begin
      fails++; $display("FAIL mid_reset_score: got score%0d lives%0d want score0 lives3", score, lives); end
    step(); reset = 0;
  endtask

  initial begin
    test_reset();
    test_capture_win(8'd1);
    test_mismatch();
    test_simultaneous();
    test_timeout();
    test_timeout_accept_game_over();
    test_capture_win(8'd1);
    test_guards_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
